// File: rtl/regfile_bwclr_pkg.sv
// regfile_pkg: shared defaults and types for the regfile_bwclr slice.
//   DEF_ADDR_W / DEF_DATA_W : default address and word widths
//   NBYTES                  : byte-lane count for the default word width
//   state_t                 : sweep/run FSM encoding
`timescale 1ns/1ps
package regfile_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int NBYTES     = DEF_DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_bwclr_byte_merge.sv
// byte_merge: combinational byte-lane merge.
//   i_old    : current word
//   i_new    : incoming word
//   i_mask   : one bit per byte lane; set lanes take i_new
//   o_merged : resulting word
`timescale 1ns/1ps
module byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_mask,
  output logic [DATA_W-1:0]   o_merged
);
  always_comb begin
    o_merged = i_old;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      if (i_mask[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
    end
  end
endmodule

// File: rtl/regfile_bwclr.sv
// regfile_bwclr: dual-read, single-write register file with byte write
// enables, registered reads and a post-reset clear sweep of every word.
//   clk, reset          : clock, synchronous active-high reset
//   wen                 : per-byte write enables for mem[waddr]
//   ren                 : read enables (bit0 port 1, bit1 port 2)
//   raddr1/2, rdata1/2  : read addresses and registered read data
//   waddr, wdata        : write address and data
//   test_addr/test_data : unregistered debug read of raw memory
//   busy                : clear sweep in progress, all accesses blocked
// Build option: define REGFILE_BYPASS_EN to forward same-edge write data
// (merged per byte) to a read of the address being written; otherwise a
// same-edge read returns the old contents.
`timescale 1ns/1ps
module regfile_bwclr
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W/8-1:0] wen,
  input  logic [1:0]          ren,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  input  logic [ADDR_W-1:0]   test_addr,
  output logic [DATA_W-1:0]   test_data,
  output logic                busy
);
  localparam int DEPTH = 1 << ADDR_W;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata1;
  logic [DATA_W-1:0]   r_rdata2;

  logic                w_wr_en;
  logic [DATA_W-1:0]   w_wr_old;
  logic [DATA_W-1:0]   w_wr_merged;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_wr_en  = (r_state == ST_RUN) && (|wen);
  assign w_wr_old = r_mem[waddr];

  // One merge unit serves both the write path and the bypass path: a
  // forwarded read only ever targets waddr, so the merged word is the same.
  byte_merge #(.DATA_W(DATA_W)) u_merge (
    .i_old    (w_wr_old),
    .i_new    (wdata),
    .i_mask   (wen),
    .o_merged (w_wr_merged)
  );

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    w_rd1 = r_mem[raddr1];
    w_rd2 = r_mem[raddr2];
    if (w_wr_en && (raddr1 == waddr)) w_rd1 = w_wr_merged;
    if (w_wr_en && (raddr2 == waddr)) w_rd2 = w_wr_merged;
  end
`else
  assign w_rd1 = r_mem[raddr1];
  assign w_rd2 = r_mem[raddr2];
`endif

  // FSM, sweep counter and read registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          if (r_clr_cnt == '1) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (ren[0]) r_rdata1 <= w_rd1;
          if (ren[1]) r_rdata2 <= w_rd2;
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Memory has no reset of its own; it is left untouched while reset is
  // held and zeroed word by word once the sweep runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) r_mem[r_clr_cnt] <= '0;
      else if (w_wr_en)        r_mem[waddr]     <= w_wr_merged;
    end
  end

  assign rdata1    = r_rdata1;
  assign rdata2    = r_rdata2;
  assign test_data = r_mem[test_addr];
  assign busy      = (r_state == ST_CLEAR);
endmodule

// File: doc/regfile_bwclr.md
# regfile_bwclr

Dual-read, single-write 32×32 register file with per-byte write enables, per-port read enables, registered read data, and a post-reset hardware clear sweep. It sits directly below the register-file display top: it consumes the read/write addresses and write data latched from the touchscreen, and returns read data plus an asynchronous test read port for the 32-register LCD scan.

## Interface
- `ADDR_W`, 5: address width; depth = 2^ADDR_W.
- `DATA_W`, 32: word width; must be a multiple of 8.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `wen`  in  DATA_W/8  byte write enables; bit i writes `wdata[8i+7:8i]`.
- `ren`  in  2  read enables; bit0 → port 1, bit1 → port 2.
- `raddr1`, `raddr2`  in  ADDR_W  read addresses.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `rdata1`, `rdata2`  out  DATA_W  registered read data.
- `test_addr`  in  ADDR_W  debug read address.
- `test_data`  out  DATA_W  combinational `mem[test_addr]`.
- `busy`  out  1  clear sweep in progress; external writes and reads are blocked.

## Operation
- FSM has two states: CLEAR and RUN.
- `reset`=1: state ← CLEAR, `clr_cnt` ← 0, `rdata1`/`rdata2` ← 0. Memory is not touched while reset is held.
- CLEAR with reset=0:
  - each cycle writes `mem[clr_cnt]` ← 0 and increments `clr_cnt`.
  - at `clr_cnt`==2^ADDR_W−1, goes to RUN after that write.
  - `wen`/`ren` are ignored; `rdata*` hold 0.
- RUN:
  - write: for each set `wen[i]`, byte i of `mem[waddr]` ← byte i of `wdata`; unset bytes are retained.
  - `wen`=0 means no write.
  - read: if `ren[k]`, `rdatak` ← `mem[raddrk]`; else `rdatak` holds its previous value.
  - both ports may read the same address.
- `busy` = (state==CLEAR), decoded from the FSM state register, not combinationally from `reset`.
- `test_data` is always the raw memory content, including during CLEAR (partially cleared words visible). It is not gated by `ren`.
- Reset asserted mid-sweep or mid-run: the sweep restarts from address 0; the full 32-cycle sweep always runs.
- All registers are writable; no hardwired zero register.

## Timing
- Reset values: `busy`=1, `rdata1`=`rdata2`=0. `test_data` is combinational and shows uncleared contents until the sweep reaches that address.
- Sweep: reset deasserted at edge E0.
  - addresses 0..31 cleared at edges E1..E32.
  - `busy` falls after E32.
  - first accepted write/read at E33.
- Read latency: 1 cycle; `raddr` sampled at edge N appears on `rdata` after edge N.
- Write visible on `test_data` after the write edge.
- Read and write to the same address at the same edge: see Configuration.
- Simultaneous read on both ports plus a write: all three happen in the same cycle; no stalls.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - same-edge read of `waddr` with `ren[k]`=1 returns merged data: bytes with `wen[i]`=1 come from `wdata`, the others from the old `mem`.
  - forwarding applies per port independently.
- Undefined: a same-edge read returns the old `mem` content (read-before-write).

## Structure
- Shared package `regfile_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - FSM state typedef with `ST_CLEAR`, `ST_RUN`.
  - byte-lane count constant `NBYTES` = DATA_W/8.
- One natural sub-module: `byte_merge`, combinational; takes old word, new word and byte mask, returns the merged word. Used for both the write path and bypass.
- The memory array, FSM, clear counter and read registers stay in the top.

## Test plan
- Reset sweep: preload mem via writes, pulse reset 1 cycle → `busy`=1 for exactly 32 cycles after release; then `rdata1` of every address = 0x00000000.
- Byte write: after sweep, write `waddr`=5, `wdata`=0xAABBCCDD, `wen`=4'b1111; then `wdata`=0x11223344, `wen`=4'b0101 → `raddr1`=5 yields 0xAA22CC44 one cycle later; `test_addr`=5 shows the same.
- Read enable hold: `ren`=2'b01, change `raddr2` from 5 to 6 → `rdata2` unchanged; `rdata1` updates.
- Same-edge read/write: mem[9]=0x0, write 0xFFFFFFFF `wen`=4'b0011 to 9 while `raddr1`=9, `ren`=2'b01 → 0x0000FFFF with `REGFILE_BYPASS_EN`, 0x00000000 without.
- Mid-sweep reset: reassert reset at sweep cycle 10, release → `busy` high another full 32 cycles; a write attempted during `busy` (`waddr`=3, 0x12345678) is absent afterwards (mem[3]=0).
- Writes blocked in CLEAR: `wen`=4'hF to address 31 on sweep cycle 1 → mem[31]=0 after sweep.
